// File: rtl/reg_file_sb.sv
// reg_file_sb: RV32I integer register file, 2 async read / 1 sync write,
// hardwired-zero r0, optional write->read bypass, optional busy scoreboard.
//
// Parameters:
//   XLEN   data width
//   NREG   architectural registers, 2..32 (any count, not only powers of 2)
//   AW     address width, derived from NREG; leave at default
//   BYPASS 1: same-cycle write data forwarded to reads; 0: stored value only
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rs1, rs2            read addresses
//   rd, wen, wdata      writeback port
//   iss_en, iss_rd      issue of an instruction that will write iss_rd
//   rdata1, rdata2      combinational read data
//   busy1, busy2        combinational pending-write flags for rs1/rs2
//
// Build option: define RF_SCOREBOARD_EN to instantiate the busy-bit
// scoreboard. Without it iss_en/iss_rd are ignored and busy1/busy2 are 0.

module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            wen,
  input  logic [XLEN-1:0] wdata,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
  localparam bit          BYP    = (BYPASS != 0);

  // Address names a real, writable register (not r0, not past NREG).
  function automatic logic in_rng(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_W);
  endfunction

  logic wr_ok;
  logic rs1_ok;
  logic rs2_ok;
  logic fwd1;
  logic fwd2;

  assign wr_ok  = wen && in_rng(rd);
  assign rs1_ok = in_rng(rs1);
  assign rs2_ok = in_rng(rs2);

  // Forward only when the write would actually land in the read register.
  assign fwd1 = BYP && wr_ok && (rd == rs1);
  assign fwd2 = BYP && wr_ok && (rd == rs2);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[rd] <= wdata;
    end
  end

  // Outputs are forced low while reset is held so that a same-cycle
  // forward of wdata cannot leak through during reset.
  always_comb begin
    rdata1 = '0;
    if (!rst && rs1_ok) begin
      rdata1 = fwd1 ? wdata : regs_q[rs1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && rs2_ok) begin
      rdata2 = fwd2 ? wdata : regs_q[rs2];
    end
  end

`ifdef RF_SCOREBOARD_EN

  logic            iss_ok;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  assign iss_ok = iss_en && in_rng(iss_rd);

  // Clear first, then set: a new producer issued in the same cycle as
  // the old one's writeback keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[rd] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A forwarded write satisfies the hazard in the same cycle.
  assign busy1 = !rst && rs1_ok && busy_q[rs1] && !fwd1;
  assign busy2 = !rst && rs2_ok && busy_q[rs2] && !fwd2;

`else

  logic unused_iss;
  assign unused_iss = ^{iss_en, iss_rd};

  assign busy1 = 1'b0;
  assign busy2 = 1'b0;

`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: random + directed check of reg_file_sb against an
// array-based reference model; two instances (NREG=32 bypass, NREG=20 no bypass).

module tb_reg_file_sb;

`ifdef RF_SCOREBOARD_EN
  localparam bit SBE = 1'b1;
`else
  localparam bit SBE = 1'b0;
`endif

  localparam int NA = 32;
  localparam int NB = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, iss_rd;
  logic        wen, iss_en;
  logic [31:0] wdata;

  logic [31:0] a1, a2, b1, b2;
  logic        ab1, ab2, bb1, bb2;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] ma [32];
  logic [31:0] mb [32];
  bit          sa [32];
  bit          sb [32];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREG(NA), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wen(wen), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
    .rdata1(a1), .rdata2(a2), .busy1(ab1), .busy2(ab2)
  );

  reg_file_sb #(.XLEN(32), .NREG(NB), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd),
    .wen(wen), .wdata(wdata), .iss_en(iss_en), .iss_rd(iss_rd),
    .rdata1(b1), .rdata2(b2), .busy1(bb1), .busy2(bb2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] e_rd(input int n, input bit byp,
                                       input int rs,
                                       input logic [31:0] v);
    if (rst) return 32'd0;
    if (rs == 0 || rs >= n) return 32'd0;
    if (byp && wen && int'(rd) == rs) return wdata;
    return v;
  endfunction

  function automatic logic [31:0] e_bsy(input int n, input bit byp,
                                        input int rs, input bit b);
    if (!SBE || rst) return 32'd0;
    if (rs == 0 || rs >= n) return 32'd0;
    if (byp && wen && int'(rd) == rs) return 32'd0;
    return {31'd0, b};
  endfunction

  task automatic check_all();
    check("a.rdata1", a1, e_rd(NA, 1'b1, int'(rs1), ma[rs1]));
    check("a.rdata2", a2, e_rd(NA, 1'b1, int'(rs2), ma[rs2]));
    check("b.rdata1", b1, e_rd(NB, 1'b0, int'(rs1), mb[rs1]));
    check("b.rdata2", b2, e_rd(NB, 1'b0, int'(rs2), mb[rs2]));
    check("a.busy1", {31'd0, ab1}, e_bsy(NA, 1'b1, int'(rs1), sa[rs1]));
    check("a.busy2", {31'd0, ab2}, e_bsy(NA, 1'b1, int'(rs2), sa[rs2]));
    check("b.busy1", {31'd0, bb1}, e_bsy(NB, 1'b0, int'(rs1), sb[rs1]));
    check("b.busy2", {31'd0, bb2}, e_bsy(NB, 1'b0, int'(rs2), sb[rs2]));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      sa[i] = 1'b0;
      sb[i] = 1'b0;
    end
  endtask

  // Writeback clears, issue then sets: issue wins on the same register.
  task automatic model_edge();
    if (rst) begin
      model_clear();
    end else begin
      if (wen && rd != 0) begin
        ma[rd] = wdata;
        sa[rd] = 1'b0;
        if (int'(rd) < NB) begin
          mb[rd] = wdata;
          sb[rd] = 1'b0;
        end
      end
      if (SBE && iss_en && iss_rd != 0) begin
        sa[iss_rd] = 1'b1;
        if (int'(iss_rd) < NB) sb[iss_rd] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic w, input logic [4:0] d,
                      input logic [31:0] wd, input logic ie,
                      input logic [4:0] ir, input logic [4:0] r1,
                      input logic [4:0] r2);
    wen = w; rd = d; wdata = wd;
    iss_en = ie; iss_rd = ir;
    rs1 = r1; rs2 = r2;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Reset raised mid-cycle with a write pending; outputs must drop at once.
  task automatic mid_reset();
    wen = 1'b1; rd = 5'd9; wdata = 32'hCAFE_F00D;
    iss_en = 1'b1; iss_rd = 5'd10;
    rs1 = 5'd9; rs2 = 5'd10;
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_all();
    check("rst.a1", a1, 32'd0);
    check("rst.b2", b2, 32'd0);
    @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    model_clear();
    rst = 1'b1;
    wen = 0; rd = 0; wdata = 0;
    iss_en = 0; iss_rd = 0;
    rs1 = 5'd3; rs2 = 5'd21;
    @(negedge clk);
    @(negedge clk);
    #1 check_all();
    check("reset.a1", a1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i), $urandom, 1'b0, 5'd0, 5'(i), 5'd0);
    end

    step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
    check("r0.next", a1, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

    wen = 1'b1; rd = 5'd5; wdata = 32'h1234_5678;
    rs1 = 5'd5; rs2 = 5'd5; iss_en = 1'b0; iss_rd = 5'd0;
    #1 check("byp.a1", a1, 32'h1234_5678);
    check("byp.a2", a2, 32'h1234_5678);
    #1 step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 5'd5, 5'd5);
    check("nobyp.b1", b1, 32'h1234_5678);

    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
    check("sb.busy7", {31'd0, ab1}, {31'd0, SBE});
    step(1'b1, 5'd7, 32'h7777_0007, 1'b0, 5'd0, 5'd7, 5'd7);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);

    step(1'b1, 5'd3, 32'h0303_0303, 1'b1, 5'd3, 5'd3, 5'd3);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    check("sb.setwins", {31'd0, ab1}, {31'd0, SBE});
    check("sb.r3", a1, 32'h0303_0303);

    step(1'b1, 5'd20, 32'hAAAA_5555, 1'b1, 5'd25, 5'd20, 5'd25);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd25);

    @(negedge clk);
    mid_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd10);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        step(1'($urandom_range(0, 1)), pick(), $urandom,
             1'($urandom_range(0, 1)), pick(), pick(), pick());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
